// File: rtl/ascon_pkg.sv
// ascon_pkg: shared definitions for the iterative ASCON permutation engine.
// - Request codes for p6/p8/p12 (plus the illegal code) and their round counts.
// - FSM state encoding used by the sequencer.
// - rc(i, n): round constant for round i of an n-round permutation.
// - ror64: 64-bit rotate right used by the linear layer.
package ascon_pkg;

  localparam int ASCON_W     = 64;
  localparam int ASCON_CNT_W = 4;

  localparam logic [1:0] ROUNDS_P6  = 2'd0;
  localparam logic [1:0] ROUNDS_P8  = 2'd1;
  localparam logic [1:0] ROUNDS_P12 = 2'd2;
  localparam logic [1:0] ROUNDS_ILL = 2'd3;

  localparam logic [ASCON_CNT_W-1:0] N_P6  = 4'd6;
  localparam logic [ASCON_CNT_W-1:0] N_P8  = 4'd8;
  localparam logic [ASCON_CNT_W-1:0] N_P12 = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Round count for a request code. The illegal code maps to p12 but is
  // never used to run rounds; the sequencer diverts it before RUN.
  function automatic logic [ASCON_CNT_W-1:0] n_of_code(input logic [1:0] code);
    logic [ASCON_CNT_W-1:0] n;
    case (code)
      ROUNDS_P6:  n = N_P6;
      ROUNDS_P8:  n = N_P8;
      ROUNDS_P12: n = N_P12;
      default:    n = N_P12;
    endcase
    return n;
  endfunction

  // An n-round permutation runs rounds (12-n)..11 of p12, so the absolute
  // round number is s+i with s = 12-n. Constant = {0xF-(s+i), s+i}.
  function automatic logic [7:0] rc(input logic [ASCON_CNT_W-1:0] i,
                                    input logic [ASCON_CNT_W-1:0] n);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = (4'd12 - n) + i;
    hi = 4'hF - lo;
    return {hi, lo};
  endfunction

  function automatic logic [ASCON_W-1:0] ror64(input logic [ASCON_W-1:0] x,
                                               input int unsigned k);
    return (x >> k) | (x << (ASCON_W - k));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational ASCON round on a 5x64 state.
// - add_constants: x2[7:0] ^= rc(round_idx, n_rounds)
// - substitution layer: bitsliced 5-bit S-box across all 64 columns
// - linear diffusion layer: per-lane xor of two rotations
// Ports:
//   x0_i..x4_i  in  64  state lanes before the round
//   round_idx   in   4  round index within the permutation (0..n-1)
//   n_rounds    in   4  permutation length (6, 8 or 12)
//   y0_o..y4_o  out 64  state lanes after the round
module ascon_round
  import ascon_pkg::*;
(
  input  logic [ASCON_W-1:0]     x0_i,
  input  logic [ASCON_W-1:0]     x1_i,
  input  logic [ASCON_W-1:0]     x2_i,
  input  logic [ASCON_W-1:0]     x3_i,
  input  logic [ASCON_W-1:0]     x4_i,
  input  logic [ASCON_CNT_W-1:0] round_idx,
  input  logic [ASCON_CNT_W-1:0] n_rounds,
  output logic [ASCON_W-1:0]     y0_o,
  output logic [ASCON_W-1:0]     y1_o,
  output logic [ASCON_W-1:0]     y2_o,
  output logic [ASCON_W-1:0]     y3_o,
  output logic [ASCON_W-1:0]     y4_o
);

  logic [ASCON_W-1:0] a0, a1, a2, a3, a4;
  logic [ASCON_W-1:0] t0, t1, t2, t3, t4;
  logic [ASCON_W-1:0] b0, b1, b2, b3, b4;

  always_comb begin
    // constant addition
    a0 = x0_i;
    a1 = x1_i;
    a2 = x2_i ^ {{(ASCON_W-8){1'b0}}, rc(round_idx, n_rounds)};
    a3 = x3_i;
    a4 = x4_i;

    // S-box input mixing
    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;

    // chi-like nonlinear core
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    b0 = a0 ^ t1;
    b1 = a1 ^ t2;
    b2 = a2 ^ t3;
    b3 = a3 ^ t4;
    b4 = a4 ^ t0;

    // S-box output mixing
    b1 = b1 ^ b0;
    b0 = b0 ^ b4;
    b3 = b3 ^ b2;
    b2 = ~b2;

    // linear diffusion
    y0_o = b0 ^ ror64(b0, 19) ^ ror64(b0, 28);
    y1_o = b1 ^ ror64(b1, 61) ^ ror64(b1, 39);
    y2_o = b2 ^ ror64(b2, 1)  ^ ror64(b2, 6);
    y3_o = b3 ^ ror64(b3, 10) ^ ror64(b3, 17);
    y4_o = b4 ^ ror64(b4, 7)  ^ ror64(b4, 41);
  end

endmodule

// File: rtl/ascon_perm_seq.sv
// ascon_perm_seq: iterative ASCON permutation sequencer. One round per clock
// through a single shared ascon_round, looping 6, 8 or 12 times per request.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     request handshake; in_rounds selects p6/p8/p12 (3 = illegal)
//   in_x0..in_x4          request state lanes, sampled only on the accept edge
//   out_valid/out_ready   result handshake; out_y0..out_y4 result lanes
//   out_err               qualifies out_valid: the request carried the illegal code
//   busy                  high while rounds are executing
//   round_idx             current round index (debug)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE, where
// the lanes and out_err stay stable until the consumer takes them. No
// outputs depend combinationally on inputs; all are flops.
module ascon_perm_seq
  import ascon_pkg::*;
#(
  parameter int W     = 64,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_rounds,
  input  logic [W-1:0]     in_x0,
  input  logic [W-1:0]     in_x1,
  input  logic [W-1:0]     in_x2,
  input  logic [W-1:0]     in_x3,
  input  logic [W-1:0]     in_x4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y0,
  output logic [W-1:0]     out_y1,
  output logic [W-1:0]     out_y2,
  output logic [W-1:0]     out_y3,
  output logic [W-1:0]     out_y4,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] round_idx
);

  state_t            state_q, state_d;
  logic [W-1:0]      lane_q [5];
  logic [W-1:0]      lane_d [5];
  logic [W-1:0]      rnd_y  [5];
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  ascon_round u_round (
    .x0_i      (lane_q[0]),
    .x1_i      (lane_q[1]),
    .x2_i      (lane_q[2]),
    .x3_i      (lane_q[3]),
    .x4_i      (lane_q[4]),
    .round_idx (idx_q),
    .n_rounds  (n_q),
    .y0_o      (rnd_y[0]),
    .y1_o      (rnd_y[1]),
    .y2_o      (rnd_y[2]),
    .y3_o      (rnd_y[3]),
    .y4_o      (rnd_y[4])
  );

  always_comb begin
    state_d = state_q;
    for (int l = 0; l < 5; l++) lane_d[l] = lane_q[l];
    n_d   = n_q;
    idx_d = idx_q;
    err_d = err_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          lane_d[0] = in_x0;
          lane_d[1] = in_x1;
          lane_d[2] = in_x2;
          lane_d[3] = in_x3;
          lane_d[4] = in_x4;
          idx_d     = '0;
          if (in_rounds == ROUNDS_ILL) begin
            // Illegal length: hand the lanes back untouched, flagged.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            n_d     = n_of_code(in_rounds);
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        for (int l = 0; l < 5; l++) lane_d[l] = rnd_y[l];
        // Stop at N-1 rather than wrapping so round_idx stays in range.
        if (idx_q == n_q - 1'b1) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      for (int l = 0; l < 5; l++) lane_q[l] <= '0;
      n_q         <= N_P12;
      idx_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int l = 0; l < 5; l++) lane_q[l] <= lane_d[l];
      n_q         <= n_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_err   = err_q;
  assign busy      = busy_q;
  assign round_idx = idx_q;
  assign out_y0    = lane_q[0];
  assign out_y1    = lane_q[1];
  assign out_y2    = lane_q[2];
  assign out_y3    = lane_q[3];
  assign out_y4    = lane_q[4];

endmodule

// File: tb/tb_ascon_perm_seq.sv
// tb_ascon_perm_seq: directed and randomized checks of ascon_perm_seq against
// a table-driven ASCON permutation model (S-box lookup, p12 constant table).
module tb_ascon_perm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_rounds;
  logic [63:0] in_x0, in_x1, in_x2, in_x3, in_x4;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_y0, out_y1, out_y2, out_y3, out_y4;
  logic        out_err;
  logic        busy;
  logic [3:0]  round_idx;

  int n_vec = 0;
  int n_err = 0;
  logic busy_seen = 1'b0;

  logic [320:0] exp_q[$];

  logic [4:0] sbox_tab [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  logic [7:0] rc_tab [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                              8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
  int rot_a [5] = '{19, 61, 1, 10, 7};
  int rot_b [5] = '{28, 39, 6, 17, 41};

  ascon_perm_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rounds (in_rounds),
    .in_x0     (in_x0),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_x3     (in_x3),
    .in_x4     (in_x4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y0    (out_y0),
    .out_y1    (out_y1),
    .out_y2    (out_y2),
    .out_y3    (out_y3),
    .out_y4    (out_y4),
    .out_err   (out_err),
    .busy      (busy),
    .round_idx (round_idx)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (busy) busy_seen = 1'b1;

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotr(input logic [63:0] x, input int k);
    return (x >> k) | (x << (64 - k));
  endfunction

  function automatic int n_of(input logic [1:0] code);
    case (code)
      2'd0:    return 6;
      2'd1:    return 8;
      default: return 12;
    endcase
  endfunction

  // Permutation p_n = the last n rounds of p12, state packed as {x0..x4}.
  function automatic logic [319:0] perm_model(input logic [319:0] st, input int n);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  o;
    for (int l = 0; l < 5; l++) x[l] = st[319-64*l -: 64];
    for (int r = 12 - n; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ rc_tab[r];
      for (int j = 0; j < 64; j++) begin
        col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
        o   = sbox_tab[col];
        for (int l = 0; l < 5; l++) y[l][j] = o[4-l];
      end
      for (int l = 0; l < 5; l++) x[l] = y[l] ^ rotr(y[l], rot_a[l]) ^ rotr(y[l], rot_b[l]);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [320:0] expect_of(input logic [1:0] code, input logic [319:0] st);
    if (code == 2'd3) return {1'b1, st};
    return {1'b0, perm_model(st, n_of(code))};
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [319:0] out_lanes();
    return {out_y0, out_y1, out_y2, out_y3, out_y4};
  endfunction

  function automatic logic [319:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge. Issues one request, measures latency from the
  // accept edge, checks the result, holds out_ready low for 'hold' cycles,
  // then completes the output handshake. Returns at a negedge.
  task automatic run_req(input string tag, input logic [1:0] code,
                         input logic [319:0] st, input int hold, input int exp_lat);
    int lat;
    logic [320:0] exp;
    exp = expect_of(code, st);
    in_rounds = code;
    {in_x0, in_x1, in_x2, in_x3, in_x4} = st;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    check({tag, "_in_ready_pre"}, in_ready, 1'b1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    // Change inputs after the accept; the engine must ignore them.
    in_valid = 1'b0;
    {in_x0, in_x1, in_x2, in_x3, in_x4} = rand_state();
    in_rounds = 2'($urandom_range(0, 3));
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_lanes"}, out_lanes(), exp[319:0]);
    check({tag, "_err"}, out_err, exp[320]);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_lanes"}, out_lanes(), exp[319:0]);
      check({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 1'b0);
    check({tag, "_post_err"}, out_err, 1'b0);
    check({tag, "_post_in_ready"}, in_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [319:0] st;
    logic [1:0]   req_code [12];
    logic [319:0] req_st   [12];
    logic [320:0] exp;
    int acc;
    int res;
    int cyc;
    bit did_acc;
    bit did_res;

    rst = 1'b1;
    in_valid = 1'b0;
    in_rounds = 2'd0;
    {in_x0, in_x1, in_x2, in_x3, in_x4} = rand_state();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // reset state
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_round_idx", round_idx, 4'd0);
    check("rst_lanes", out_lanes(), 320'd0);
    rst = 1'b0;
    out_ready = 1'b0;

    // p6 on zero state, out_ready high throughout
    busy_seen = 1'b0;
    run_req("p6_zero", 2'd0, 320'd0, 0, 7);
    check("p6_busy_seen", busy_seen, 1'b1);

    // p12 on the ASCON-128 initial state (IV, key=0, nonce=0)
    st = {64'h80400c0600000000, 64'd0, 64'd0, 64'd0, 64'd0};
    run_req("p12_iv", 2'd2, st, 0, 13);

    // p8 with 5 cycles of back-pressure, then an immediate follow-on p6
    run_req("p8_hold", 2'd1, rand_state(), 5, 9);
    run_req("p6_after_hold", 2'd0, rand_state(), 0, 7);

    // illegal length: lanes pass through flagged, no rounds
    busy_seen = 1'b0;
    run_req("ill", 2'd3, rand_state(), 2, 2 - 1);
    check("ill_busy_never", busy_seen, 1'b0);

    // reset in the middle of a p12 at round_idx 4
    in_rounds = 2'd2;
    {in_x0, in_x1, in_x2, in_x3, in_x4} = rand_state();
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_round_idx", round_idx, 4'd4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_round_idx", round_idx, 4'd0);
    run_req("p6_after_rst", 2'd0, rand_state(), 0, 7);

    // back-to-back stream, in_valid held high, random out_ready
    req_code[0] = 2'd0;
    req_code[1] = 2'd1;
    req_code[2] = 2'd2;
    for (int r = 3; r < 12; r++) req_code[r] = 2'($urandom_range(0, 3));
    for (int r = 0; r < 12; r++) req_st[r] = rand_state();
    acc = 0;
    res = 0;
    cyc = 0;
    while (res < 12 && cyc < 3000) begin
      in_valid  = (acc < 12);
      in_rounds = req_code[acc < 12 ? acc : 11];
      {in_x0, in_x1, in_x2, in_x3, in_x4} = req_st[acc < 12 ? acc : 11];
      out_ready = 1'($urandom_range(0, 1));
      did_acc = in_valid && in_ready;
      did_res = out_valid && out_ready;
      if (did_res) begin
        check("b2b_result_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check("b2b_lanes", out_lanes(), exp[319:0]);
          check("b2b_err", out_err, exp[320]);
        end
        res++;
      end
      if (did_acc) begin
        exp_q.push_back(expect_of(req_code[acc], req_st[acc]));
        acc++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepted", acc, 12);
    check("b2b_results", res, 12);
    check("b2b_queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("b2b_no_extra_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
